// File: rtl/button_pkg.sv
// Shared state encoding and default 50 MHz timing for the push-button event controller.
// Constants only; no logic, latency or flow control.
package button_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        REPEAT   = 2'd3
    } btn_state_t;

    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 12_500_000;
    localparam int DEF_NUM_MODES     = 4;
    localparam int DEF_MODE_W        = 2;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/mode_wrap_counter.sv
// Wrapping mode index 0..NUM_MODES-1, advanced by one on each inc cycle.
// Registered output, one cycle after inc; inc is always accepted.
module mode_wrap_counter #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [MODE_W-1:0] mode
);

    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;

    // Compare-and-clear so non-power-of-two mode counts wrap correctly.
    always_comb begin
        mode_d = mode_q;
        if (inc) begin
            if (mode_q >= MODE_MAX) begin
                mode_d = '0;
            end else begin
                mode_d = mode_q + MODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode = mode_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into press/release/long-press/repeat pulses and a mode index.
// All outputs registered, one cycle after the deciding edge; no backpressure, input sampled every cycle.
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int NUM_MODES     = DEF_NUM_MODES,
    parameter int MODE_W        = DEF_MODE_W,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debounce,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_press,
    output logic              repeat_pulse,
    output logic              held,
    output logic [MODE_W-1:0] mode
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic             mode_inc;

    // Release is checked before the terminal count so a simultaneous release wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        mode_inc  = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                cnt_d = '0;
                if (!debounce) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (debounce) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (!debounce) begin
                    release_d = 1'b1;
                    mode_inc  = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_TERM) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!debounce) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == REP_TERM) begin
                    repeat_d = 1'b1;
                    mode_inc = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOW;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    mode_wrap_counter #(
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode_inc),
        .mode  (mode)
    );

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button traffic against an event-level model.
module tb_button_event_ctrl;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int NM   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       debounce = 1'b1;
    logic       press_pulse, release_pulse, long_press, repeat_pulse, held;
    logic [1:0] mode;
    logic [6:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Event-level reference: armed = a low level was seen since reset, h = edges held since press.
    bit m_armed, m_pressed, m_press, m_rel, m_long, m_rep, m_held;
    int m_h, m_mode;

    button_event_ctrl #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .NUM_MODES     (NM),
        .MODE_W        (2),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .debounce      (debounce),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    assign obs = {press_pulse, release_pulse, long_press, repeat_pulse, held, mode};

    function automatic logic [6:0] exp_vec();
        return {m_press, m_rel, m_long, m_rep, m_held, 2'(m_mode)};
    endfunction

    task automatic model_step(input bit d, input bit r);
        m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
        if (!r) begin
            m_armed = 0; m_pressed = 0; m_h = 0; m_mode = 0;
        end else if (!m_armed) begin
            if (!d) m_armed = 1;
        end else if (!m_pressed) begin
            if (d) begin
                m_press = 1; m_pressed = 1; m_h = 0;
            end
        end else if (!d) begin
            m_rel = 1; m_pressed = 0;
            if (m_h < LONG) m_mode = (m_mode + 1) % NM;
        end else begin
            m_h++;
            if (m_h == LONG) m_long = 1;
            else if (m_h > LONG && (m_h - LONG) % REP == 0) begin
                m_rep = 1; m_mode = (m_mode + 1) % NM;
            end
        end
        m_held = r && m_pressed;
    endtask

    task automatic tick(input bit d, input bit r);
        debounce = d;
        rst_n = r;
        @(posedge clk);
        model_step(d, r);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0);
            n_cmp++;
            if (obs !== 7'd0) begin
                n_bad++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, 7'd0);
            end
        end
    endtask

    task automatic test_held_through_reset();
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1);
            pulses += int'(press_pulse) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++; $display("FAIL s1_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        n_cmp++;
        if (pulses !== 0 || mode !== 2'd0) begin
            n_bad++; $display("FAIL s1_silent pulses=%0d mode=%0d exp 0/0", pulses, mode);
        end
        tick(0, 1);
        tick(1, 1);
        n_cmp++;
        if (press_pulse !== 1'b1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL s1_press got=%b exp=%b", obs, exp_vec());
        end
        tick(0, 1);
        n_cmp++;
        if (release_pulse !== 1'b1 || mode !== 2'd1 || held !== 1'b0) begin
            n_bad++; $display("FAIL s1_release rel=%b mode=%0d held=%b exp 1/1/0", release_pulse, mode, held);
        end
        tick(0, 1);
    endtask

    task automatic test_short_presses();
        int np = 0, nr = 0, nl = 0;
        int start = m_mode;
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                tick(i < 3, 1);
                np += int'(press_pulse); nr += int'(release_pulse); nl += int'(long_press);
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++; $display("FAIL s2_cycle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
                end
            end
            n_cmp++;
            if (int'(mode) !== (start + k) % NM) begin
                n_bad++; $display("FAIL s2_mode press=%0d got=%0d exp=%0d", k, mode, (start + k) % NM);
            end
        end
        n_cmp++;
        if (np !== 3 || nr !== 3 || nl !== 0) begin
            n_bad++; $display("FAIL s2_counts press=%0d rel=%0d long=%0d exp 3/3/0", np, nr, nl);
        end
    endtask

    task automatic test_long_hold();
        int p_cyc = -1, l_cyc = -1, nrep = 0, start;
        int rep_cyc[$];
        start = m_mode;
        for (int i = 0; i < 30; i++) begin
            tick(1, 1);
            if (press_pulse) p_cyc = cyc;
            if (long_press) l_cyc = cyc;
            if (repeat_pulse) rep_cyc.push_back(cyc);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++; $display("FAIL s3_cycle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        n_cmp++;
        if (l_cyc - p_cyc !== LONG) begin
            n_bad++; $display("FAIL s3_long_delay got=%0d exp=%0d", l_cyc - p_cyc, LONG);
        end
        nrep = rep_cyc.size();
        n_cmp++;
        if (nrep !== (29 - LONG) / REP) begin
            n_bad++; $display("FAIL s3_repeat_count got=%0d exp=%0d", nrep, (29 - LONG) / REP);
        end
        foreach (rep_cyc[i]) begin
            n_cmp++;
            if (rep_cyc[i] - l_cyc !== REP * (i + 1)) begin
                n_bad++; $display("FAIL s3_repeat_gap idx=%0d got=%0d exp=%0d", i, rep_cyc[i] - l_cyc, REP * (i + 1));
            end
        end
        n_cmp++;
        if (int'(mode) !== (start + nrep) % NM) begin
            n_bad++; $display("FAIL s3_mode_held got=%0d exp=%0d", mode, (start + nrep) % NM);
        end
        tick(0, 1);
        n_cmp++;
        if (release_pulse !== 1'b1 || int'(mode) !== (start + nrep) % NM) begin
            n_bad++; $display("FAIL s3_release rel=%b mode=%0d exp 1/%0d", release_pulse, mode, (start + nrep) % NM);
        end
        for (int i = 0; i < 3; i++) tick(0, 1);
    endtask

    task automatic test_release_at_terminal();
        int start = m_mode;
        tick(1, 1);
        for (int i = 0; i < LONG - 1; i++) tick(1, 1);
        tick(0, 1);
        n_cmp++;
        if (release_pulse !== 1'b1 || long_press !== 1'b0 || int'(mode) !== (start + 1) % NM) begin
            n_bad++; $display("FAIL s4_race rel=%b long=%b mode=%0d exp 1/0/%0d", release_pulse, long_press, mode, (start + 1) % NM);
        end
        tick(0, 1);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++; $display("FAIL s4_after got=%b exp=%b", obs, exp_vec());
        end
    endtask

    task automatic test_reset_in_repeat();
        int pulses = 0;
        for (int i = 0; i < LONG + 3; i++) tick(1, 1);
        n_cmp++;
        if (held !== 1'b1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL s5_in_repeat got=%b exp=%b", obs, exp_vec());
        end
        tick(1, 0);
        n_cmp++;
        if (obs !== 7'd0) begin
            n_bad++; $display("FAIL s5_reset got=%b exp=%b", obs, 7'd0);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, 1);
            pulses += int'(press_pulse) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse) + int'(held);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL s5_no_event got=%0d exp=0", pulses);
        end
        tick(0, 1);
        tick(1, 1);
        n_cmp++;
        if (press_pulse !== 1'b1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL s5_repress got=%b exp=%b", obs, exp_vec());
        end
        tick(0, 1);
        tick(0, 1);
    endtask

    task automatic test_random();
        bit d = 0;
        bit r;
        int run;
        int total = 0;
        while (total < 1500) begin
            d = ~d;
            run = $urandom_range(1, 14);
            r = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < run; i++) begin
                tick(d, (i == 0) ? r : 1'b1);
                total++;
                n_cmp++;
                if (obs !== exp_vec() || $countones({press_pulse, release_pulse, long_press, repeat_pulse}) > 1) begin
                    n_bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_short_presses();
        test_long_hold();
        test_release_at_terminal();
        test_reset_in_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Consumes the clean, synchronized level from the push-button debouncer and turns it into discrete user events: press and release pulses, long-press detection, and auto-repeat while held.
- Maintains a wrap-around mode index that the VGA pattern/colour selector reads directly.
- Sits between the debouncer output and the VGA controller's mode logic, in the same clock domain.

Parameters:
- LONG_CYCLES, 50000000, cycles held after press_pulse before long_press fires (1 s at 50 MHz); must be >= 2
- REPEAT_CYCLES, 12500000, cycles between long_press and first repeat_pulse, and between successive repeat_pulses; must be >= 2
- NUM_MODES, 4, number of mode values; mode counts 0..NUM_MODES-1; must be >= 2
- MODE_W, 2, width of mode; must satisfy 2**MODE_W >= NUM_MODES
- CNT_W, 26, hold-counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- debounce  in  1  debounced button level, already synchronous to clk
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on release
- long_press  out  1  one-cycle pulse when hold reaches LONG_CYCLES
- repeat_pulse  out  1  one-cycle auto-repeat pulse
- held  out  1  high while state is PRESSED or REPEAT
- mode  out  MODE_W  current mode index

Behaviour:
- All outputs are registered. Reset is sampled only on posedge clk with rst_n=0.
- Reset values: all pulses 0, held 0, mode 0, cnt 0, state WAIT_LOW. Reset mid-operation aborts any hold with no release_pulse.
- States: WAIT_LOW, IDLE, PRESSED, REPEAT.
- WAIT_LOW: stays while debounce=1, so a button held through reset produces no event. Goes to IDLE on the first edge that samples debounce=0.
- IDLE, edge samples debounce=1:
  - press_pulse=1 for the following cycle
  - goto PRESSED, cnt<=0
- PRESSED, edge samples debounce=0:
  - release_pulse=1
  - mode<=mode+1, wrapping NUM_MODES-1 -> 0 (short press)
  - goto IDLE
- PRESSED, debounce=1 and cnt==LONG_CYCLES-1:
  - long_press=1, cnt<=0, goto REPEAT
  - mode unchanged
- PRESSED, debounce=1 otherwise: cnt<=cnt+1.
- Resulting long-press timing: long_press rises exactly LONG_CYCLES cycles after press_pulse.
- REPEAT, debounce=0: release_pulse=1, goto IDLE, mode unchanged.
- REPEAT, debounce=1 and cnt==REPEAT_CYCLES-1: repeat_pulse=1, mode<=mode+1 (wrap), cnt<=0.
- REPEAT, debounce=1 otherwise: cnt<=cnt+1.
- Resulting repeat timing: repeat_pulses occur REPEAT_CYCLES after long_press, then every REPEAT_CYCLES.
- held=1 in the cycle after entering PRESSED, through the cycle the release is registered; it falls together with release_pulse.
- Simultaneous events: release sampled on the same edge the counter reaches terminal means release wins; no long_press/repeat_pulse and no extra mode step.
- At most one pulse output is high in any cycle.
- Mode arithmetic: compare-and-clear wrap, not a power-of-two overflow. mode never exceeds NUM_MODES-1.
- Minimum press: one cycle high then low gives press_pulse, then release_pulse on the next cycle, mode+1.
- cnt never exceeds its terminal value. It is held at 0 in WAIT_LOW and IDLE.

Decomposition:
- Package button_pkg holds:
  - state encoding constants (WAIT_LOW=2'd0, IDLE=2'd1, PRESSED=2'd2, REPEAT=2'd3)
  - default timing constants for 50 MHz
- Sub-module mode_wrap_counter(clk, rst_n, inc, mode; NUM_MODES, MODE_W) owns the wrapping mode register. It is instantiated once and driven by (short release | repeat_pulse).
- FSM and hold counter stay in the top module.

Test Plan:
- All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, NUM_MODES=3, MODE_W=2.
- Scenario 1, reset with debounce=1 held for 20 cycles, then low: no pulses, mode=0; the next 1-cycle high gives press_pulse, then release_pulse, mode=1.
- Scenario 2, three short presses (high 3 cycles, low 5 cycles):
  - mode goes 1, 2, 0 (wrap)
  - exactly 3 press_pulse and 3 release_pulse
  - never a long_press
- Scenario 3, hold high for 30 cycles:
  - long_press exactly 8 cycles after press_pulse
  - repeat_pulses at +4, +8, +12, ... after long_press
  - mode increments once per repeat_pulse
  - the final release gives release_pulse with no mode step
- Scenario 4, drop debounce low on the edge where cnt==7 in PRESSED: release_pulse, no long_press, mode+1.
- Scenario 5, assert rst_n=0 for 1 cycle during REPEAT with debounce still high:
  - all outputs clear
  - state WAIT_LOW, no release_pulse
  - no press until debounce has gone low then high again
